// File: rtl/mm_ctrl.sv
// mm_ctrl: sequences one N x N matrix multiply over a row-parallel PE array.
// Loads A rows into the PEs, then per column streams B, waits for done and drains results.
module mm_ctrl #(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 32,
    parameter int TIMEOUT     = N + 4,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic                     a_rd_en_o,
    output logic [IDX_W-1:0]         a_rd_row_o,
    output logic                     b_rd_en_o,
    output logic [IDX_W-1:0]         b_rd_k_o,
    output logic [IDX_W-1:0]         b_rd_j_o,
    output logic [N-1:0]             pe_load_row_o,
    output logic                     pe_start_o,
    input  logic [N-1:0]             pe_done_i,
    input  logic [N-1:0]             pe_err_i,
    input  logic [N*ACCUM_WIDTH-1:0] pe_total_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [ACCUM_WIDTH-1:0]   res_data_o,
    output logic [IDX_W-1:0]         res_row_o,
    output logic [IDX_W-1:0]         res_col_o,
    output logic                     job_done_o,
    output logic                     job_err_o
);

    localparam int               TMO_W = $clog2(TIMEOUT + 2);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    if (ACCUM_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
        $error("mm_ctrl: ACCUM_WIDTH cannot hold a full DATA_WIDTH product");
    end

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_WAIT, START, STREAM, WAIT, DRAIN, DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q, col_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               err_q, err_d, timeout;
    logic               cmd_ready_q, a_rd_en_q, b_rd_en_q, pe_start_q;
    logic               res_valid_q, job_done_q, job_err_q;
    logic [IDX_W-1:0]   a_rd_row_q, b_rd_k_q, b_rd_j_q, res_row_q, res_col_q;
    logic [N-1:0]       pe_load_row_q;
    logic [ACCUM_WIDTH-1:0] totals [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign totals[g] = pe_total_i[g*ACCUM_WIDTH +: ACCUM_WIDTH];
    end

    // Sticky error: PE overflow, PEs finishing out of lockstep, or no done within the timeout.
    assign timeout = (state_q == WAIT) && !(|pe_done_i) && (tmo_q >= TMO_W'(TIMEOUT));

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE) begin
            if (cmd_valid_i && cmd_ready_q) err_d = 1'b0;
        end else if ((|pe_err_i) || ((|pe_done_i) && !(&pe_done_i)) || timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            col_q         <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            a_rd_en_q     <= 1'b0;
            a_rd_row_q    <= '0;
            b_rd_en_q     <= 1'b0;
            b_rd_k_q      <= '0;
            b_rd_j_q      <= '0;
            pe_load_row_q <= '0;
            pe_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_row_q     <= '0;
            res_col_q     <= '0;
            job_done_q    <= 1'b0;
            job_err_q     <= 1'b0;
        end else begin
            err_q         <= err_d;
            cmd_ready_q   <= 1'b0;
            a_rd_en_q     <= 1'b0;
            a_rd_row_q    <= '0;
            b_rd_en_q     <= 1'b0;
            b_rd_k_q      <= '0;
            b_rd_j_q      <= '0;
            pe_load_row_q <= '0;
            pe_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_row_q     <= '0;
            res_col_q     <= '0;
            job_done_q    <= 1'b0;
            job_err_q     <= 1'b0;
            // Outputs are assigned for the state being entered, so they are all registered.
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        state_q   <= LOAD_A;
                        cnt_q     <= '0;
                        a_rd_en_q <= 1'b1;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                LOAD_A: begin
                    pe_load_row_q <= N'(1) << cnt_q;
                    if (cnt_q != LAST) begin
                        cnt_q      <= cnt_q + 1'b1;
                        a_rd_en_q  <= 1'b1;
                        a_rd_row_q <= cnt_q + 1'b1;
                    end else begin
                        state_q <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    state_q    <= START;
                    col_q      <= '0;
                    pe_start_q <= 1'b1;
                    b_rd_en_q  <= 1'b1;
                end
                START: begin
                    tmo_q <= TMO_W'(1);
                    if (N == 1) begin
                        state_q <= WAIT;
                    end else begin
                        state_q   <= STREAM;
                        cnt_q     <= IDX_W'(1);
                        b_rd_en_q <= 1'b1;
                        b_rd_k_q  <= IDX_W'(1);
                        b_rd_j_q  <= col_q;
                    end
                end
                STREAM: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (cnt_q != LAST) begin
                        cnt_q     <= cnt_q + 1'b1;
                        b_rd_en_q <= 1'b1;
                        b_rd_k_q  <= cnt_q + 1'b1;
                        b_rd_j_q  <= col_q;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (|pe_done_i) begin
                        state_q     <= DRAIN;
                        cnt_q       <= '0;
                        res_valid_q <= 1'b1;
                        res_col_q   <= col_q;
                    end else if (timeout) begin
                        state_q    <= DONE;
                        job_done_q <= 1'b1;
                        job_err_q  <= err_d;
                    end
                end
                DRAIN: begin
                    if (!res_ready_i) begin
                        res_valid_q <= 1'b1;
                        res_row_q   <= cnt_q;
                        res_col_q   <= col_q;
                    end else if (cnt_q != LAST) begin
                        cnt_q       <= cnt_q + 1'b1;
                        res_valid_q <= 1'b1;
                        res_row_q   <= cnt_q + 1'b1;
                        res_col_q   <= col_q;
                    end else if (col_q != LAST) begin
                        state_q    <= START;
                        col_q      <= col_q + 1'b1;
                        pe_start_q <= 1'b1;
                        b_rd_en_q  <= 1'b1;
                        b_rd_j_q   <= col_q + 1'b1;
                    end else begin
                        state_q    <= DONE;
                        job_done_q <= 1'b1;
                        job_err_q  <= err_d;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign a_rd_en_o     = a_rd_en_q;
    assign a_rd_row_o    = a_rd_row_q;
    assign b_rd_en_o     = b_rd_en_q;
    assign b_rd_k_o      = b_rd_k_q;
    assign b_rd_j_o      = b_rd_j_q;
    assign pe_load_row_o = pe_load_row_q;
    assign pe_start_o    = pe_start_q;
    assign res_valid_o   = res_valid_q;
    assign res_row_o     = res_row_q;
    assign res_col_o     = res_col_q;
    assign res_data_o    = res_valid_q ? totals[res_row_q] : '0;
    assign job_done_o    = job_done_q;
    assign job_err_o     = job_err_q;

endmodule

// File: tb/tb_mm_ctrl.sv
// Testbench for mm_ctrl at N=2: behavioural A/B memories and PE pair, plus stub PE
// behaviours (never done, one PE late, overflow flag) selected by peMode.
module tb_mm_ctrl;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              res_ready = 1'b0;
    logic              cmd_ready, a_rd_en, b_rd_en, pe_start, res_valid, job_done, job_err;
    logic [0:0]        a_rd_row, b_rd_k, b_rd_j, res_row, res_col;
    logic [N-1:0]      pe_load_row, pe_done, pe_err;
    logic [N*32-1:0]   pe_total;
    logic [31:0]       res_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int peMode = 0;

    typedef struct {
        int          stall;
        logic        row;
        logic        col;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [4];

    logic [1:0][15:0] memA [2];
    logic [1:0][15:0] memB [2];
    logic [1:0][15:0] aData;
    logic [1:0][15:0] aRow [2];
    logic [15:0]      colEntry;
    logic [31:0]      acc [2];
    int               ph = 0;
    logic             doneQ = 1'b0;

    mm_ctrl #(.N(N), .DATA_WIDTH(16), .ACCUM_WIDTH(32), .TIMEOUT(N + 4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .a_rd_en_o(a_rd_en), .a_rd_row_o(a_rd_row),
        .b_rd_en_o(b_rd_en), .b_rd_k_o(b_rd_k), .b_rd_j_o(b_rd_j),
        .pe_load_row_o(pe_load_row), .pe_start_o(pe_start),
        .pe_done_i(pe_done), .pe_err_i(pe_err), .pe_total_i(pe_total),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .res_row_o(res_row), .res_col_o(res_col),
        .job_done_o(job_done), .job_err_o(job_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PE model: consumes col_entry for N cycles after start, pulses done at START+N+2.
    always @(posedge clk) begin
        if (a_rd_en) aData <= memA[a_rd_row];
        if (b_rd_en) colEntry <= memB[b_rd_k][b_rd_j];
        for (int i = 0; i < N; i++) if (pe_load_row[i]) aRow[i] <= aData;
        if (pe_start) begin
            ph <= 1;
            acc[0] <= 32'd0;
            acc[1] <= 32'd0;
            doneQ <= 1'b0;
        end else if (ph >= 1 && ph <= N) begin
            for (int i = 0; i < N; i++)
                acc[i] <= acc[i] + 32'(aRow[i][ph-1]) * 32'(colEntry);
            ph <= ph + 1;
            doneQ <= 1'b0;
        end else if (ph == N + 1) begin
            doneQ <= 1'b1;
            ph <= 0;
        end else begin
            doneQ <= 1'b0;
        end
    end

    assign pe_done  = (peMode == 1) ? 2'b00 : (peMode == 2) ? {1'b0, doneQ} : {doneQ, doneQ};
    assign pe_err   = (peMode == 3) ? {1'b0, doneQ} : 2'b00;
    assign pe_total = {acc[1], acc[0]};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one job; results are checked against tbl and the done cycle against acceptance.
    task automatic applyStimulus(input int mode, input bit useStall, input int expResults,
                                 input bit expErr, input int doneOffset, input string name);
        int accCyc, n, held, stallSum;
        bit gotDone, sawStart;
        peMode = mode;
        @(negedge clk);
        checkOutput({name, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        accCyc = cyc;
        n = 0; held = 0; stallSum = 0; gotDone = 1'b0; sawStart = 1'b0;
        for (int t = 0; t < 300 && !gotDone; t++) begin
            @(negedge clk);
            cmd_valid = (t == 5);
            if (pe_start && !sawStart) begin
                sawStart = 1'b1;
                checkOutput({name, " first start cycle"}, 32'(cyc - accCyc), 32'd4);
            end
            if (res_valid) begin
                if (n >= expResults) begin
                    checkOutput({name, " unexpected result"}, 32'(n), 32'(expResults));
                    res_ready = 1'b1;
                    n++;
                end else begin
                    checkOutput({name, " res_row"}, 32'(res_row), 32'(tbl[n].row));
                    checkOutput({name, " res_col"}, 32'(res_col), 32'(tbl[n].col));
                    checkOutput({name, " res_data"}, res_data, tbl[n].data);
                    if (useStall && held < tbl[n].stall) begin
                        res_ready = 1'b0;
                        held++;
                        stallSum++;
                    end else begin
                        res_ready = 1'b1;
                        held = 0;
                        n++;
                    end
                end
            end else begin
                res_ready = 1'b1;
            end
            if (job_done) begin
                gotDone = 1'b1;
                checkOutput({name, " job_done cycle"}, 32'(cyc - accCyc), 32'(doneOffset + stallSum));
                checkOutput({name, " job_err"}, 32'(job_err), 32'(expErr));
                checkOutput({name, " result count"}, 32'(n), 32'(expResults));
            end
        end
        if (!gotDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s job_done: got none within 300 cycles, expected one", name);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, " cmd_ready after done"}, 32'(cmd_ready), 32'd1);
        checkOutput({name, " job_done one cycle"}, 32'(job_done), 32'd0);
    endtask

    initial begin
        memA[0] = {16'd2, 16'd1};
        memA[1] = {16'd4, 16'd3};
        memB[0] = {16'd6, 16'd5};
        memB[1] = {16'd8, 16'd7};
        tbl[0] = '{stall: 0, row: 1'b0, col: 1'b0, data: 32'd19};
        tbl[1] = '{stall: 2, row: 1'b1, col: 1'b0, data: 32'd43};
        tbl[2] = '{stall: 0, row: 1'b0, col: 1'b1, data: 32'd22};
        tbl[3] = '{stall: 1, row: 1'b1, col: 1'b1, data: 32'd50};

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset outputs", {24'd0, a_rd_en, b_rd_en, pe_start, res_valid,
                    job_done, job_err, pe_load_row}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 1'b0, 4, 1'b0, 18, "basic");
        applyStimulus(0, 1'b1, 4, 1'b0, 18, "stall");
        applyStimulus(3, 1'b0, 4, 1'b1, 18, "overflow");
        applyStimulus(0, 1'b0, 4, 1'b0, 18, "after overflow");
        applyStimulus(1, 1'b0, 0, 1'b1, 11, "timeout");
        applyStimulus(2, 1'b0, 4, 1'b1, 18, "late pe");

        // Reset in the middle of a drain, then a clean job from row 0, column 0.
        peMode = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 0; t < 50 && !res_valid; t++) @(negedge clk);
        checkOutput("mid-drain res_valid reached", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-drain reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid-drain reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid-drain reset res_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 4, 1'b0, 18, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
